iact_glb_loader: RTL and testbench

Upstream feeder for the iact SRAM bank in the GLB cluster. It accepts one tagged stream of compressed iact words from the top-level DMA and splits it into the bank's address channel (7-bit) and data channel (12-bit). It also pulses the bank's write enable and waits for the bank's combined write-done. It guarantees that each channel carries exactly one zero end sign, forcing one if the depth limit is reached.

---
 rtl/iact_glb_loader.sv | 218 +++++++++++++++++++++
 tb/tb_iact_glb_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iact_glb_loader.sv
// iact_glb_loader: splits one tagged DMA stream of compressed iact words into
// the address and data channels of the GLB iact SRAM bank, pulses the bank
// write enable, and waits for the bank's write-done. Each channel is
// guaranteed to carry exactly one zero end sign; one is forced if the
// channel's depth limit is reached first.
module iact_glb_loader #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 12,
   parameter int ADDR_DEPTH = 1024,
   parameter int DATA_DEPTH = 1024,
   parameter int CNT_W      = 11
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_start,
   output logic              busy,
   output logic              load_done,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [12:0]       src_data,
   output logic              iact_address_in_valid,
   input  logic              iact_address_in_ready,
   output logic [ADDR_W-1:0] iact_address_in,
   output logic              iact_data_in_valid,
   input  logic              iact_data_in_ready,
   output logic [DATA_W-1:0] iact_data_in,
   output logic              iact_write_en,
   input  logic              iact_write_done,
   output logic [CNT_W-1:0]  addr_count,
   output logic [CNT_W-1:0]  data_count,
   output logic              overflow_err,
   output logic              seq_err
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      STREAM,
      WAIT_DONE,
      DONE
   } state_t;

   state_t              r_state;
   logic                r_writeEn;
   logic                r_loadDone;
   logic                r_addrValid;
   logic [ADDR_W-1:0]   r_addrBuf;
   logic                r_dataValid;
   logic [DATA_W-1:0]   r_dataBuf;
   logic                r_addrEnd;
   logic                r_dataEnd;
   logic                r_doneLatch;
   logic [CNT_W-1:0]    r_addrCnt;
   logic [CNT_W-1:0]    r_dataCnt;
   logic                r_overflowErr;
   logic                r_seqErr;

   logic                w_isAddr;
   logic [ADDR_W-1:0]   w_addrPayload;
   logic [DATA_W-1:0]   w_dataPayload;
   logic                w_inStream;
   logic                w_addrDrain;
   logic                w_dataDrain;
   logic                w_addrRoom;
   logic                w_dataRoom;
   logic                w_srcReady;
   logic                w_accept;
   logic                w_addrTake;
   logic                w_dataTake;
   logic                w_seqHit;
   logic                w_addrForce;
   logic                w_dataForce;
   logic                w_addrEndNow;
   logic                w_dataEndNow;

   // Steering and flow control: a word is taken when its channel buffer has
   // room (empty or draining this cycle), or when that channel has already
   // ended, in which case the word is swallowed and flagged as a sequence error.
   always_comb begin
      w_isAddr      = src_data[12];
      w_addrPayload = src_data[ADDR_W-1:0];
      w_dataPayload = src_data[DATA_W-1:0];
      w_inStream    = (r_state == STREAM);
      w_addrDrain   = r_addrValid & iact_address_in_ready;
      w_dataDrain   = r_dataValid & iact_data_in_ready;
      w_addrRoom    = ~r_addrValid | w_addrDrain | r_addrEnd;
      w_dataRoom    = ~r_dataValid | w_dataDrain | r_dataEnd;
      w_srcReady    = w_inStream & (w_isAddr ? w_addrRoom : w_dataRoom);
      w_accept      = src_valid & w_srcReady;
      w_addrTake    = w_accept & w_isAddr & ~r_addrEnd;
      w_dataTake    = w_accept & ~w_isAddr & ~r_dataEnd;
      w_seqHit      = w_accept & (w_isAddr ? r_addrEnd : r_dataEnd);
      w_addrForce   = (r_addrCnt == CNT_W'(ADDR_DEPTH - 1)) & (w_addrPayload != '0);
      w_dataForce   = (r_dataCnt == CNT_W'(DATA_DEPTH - 1)) & (w_dataPayload != '0);
      w_addrEndNow  = (w_addrPayload == '0) | w_addrForce;
      w_dataEndNow  = (w_dataPayload == '0) | w_dataForce;
   end

   // One-entry output buffer per channel; a new word may load in the same
   // cycle the old one drains, and a forced terminator replaces the payload.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addrValid <= 1'b0;
         r_addrBuf   <= '0;
         r_dataValid <= 1'b0;
         r_dataBuf   <= '0;
      end else begin
         if (w_addrTake) begin
            r_addrValid <= 1'b1;
            r_addrBuf   <= w_addrForce ? '0 : w_addrPayload;
         end else if (w_addrDrain) begin
            r_addrValid <= 1'b0;
         end
         if (w_dataTake) begin
            r_dataValid <= 1'b1;
            r_dataBuf   <= w_dataForce ? '0 : w_dataPayload;
         end else if (w_dataDrain) begin
            r_dataValid <= 1'b0;
         end
      end
   end

   // Load sequencer: issues the write-enable pulse, tracks counters, end
   // flags and sticky errors, latches an early write-done, and pulses done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_writeEn     <= 1'b0;
         r_loadDone    <= 1'b0;
         r_addrEnd     <= 1'b0;
         r_dataEnd     <= 1'b0;
         r_doneLatch   <= 1'b0;
         r_addrCnt     <= '0;
         r_dataCnt     <= '0;
         r_overflowErr <= 1'b0;
         r_seqErr      <= 1'b0;
      end else begin
         r_writeEn  <= 1'b0;
         r_loadDone <= 1'b0;
         case (r_state)
            IDLE: begin
               if (load_start) begin
                  r_addrEnd     <= 1'b0;
                  r_dataEnd     <= 1'b0;
                  r_doneLatch   <= 1'b0;
                  r_addrCnt     <= '0;
                  r_dataCnt     <= '0;
                  r_overflowErr <= 1'b0;
                  r_seqErr      <= 1'b0;
                  r_writeEn     <= 1'b1;
                  r_state       <= START;
               end
            end
            START: begin
               r_state <= STREAM;
            end
            STREAM: begin
               if (w_addrTake) begin
                  r_addrCnt <= r_addrCnt + CNT_W'(1);
                  if (w_addrEndNow) begin
                     r_addrEnd <= 1'b1;
                  end
                  if (w_addrForce) begin
                     r_overflowErr <= 1'b1;
                  end
               end
               if (w_dataTake) begin
                  r_dataCnt <= r_dataCnt + CNT_W'(1);
                  if (w_dataEndNow) begin
                     r_dataEnd <= 1'b1;
                  end
                  if (w_dataForce) begin
                     r_overflowErr <= 1'b1;
                  end
               end
               if (w_seqHit) begin
                  r_seqErr <= 1'b1;
               end
               if (iact_write_done) begin
                  r_doneLatch <= 1'b1;
               end
               if (r_addrEnd && r_dataEnd && !r_addrValid && !r_dataValid) begin
                  r_state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (iact_write_done) begin
                  r_doneLatch <= 1'b1;
               end
               if (r_doneLatch || iact_write_done) begin
                  r_loadDone <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy                  = (r_state != IDLE);
   assign load_done             = r_loadDone;
   assign src_ready             = w_srcReady;
   assign iact_address_in_valid = r_addrValid;
   assign iact_address_in       = r_addrBuf;
   assign iact_data_in_valid    = r_dataValid;
   assign iact_data_in          = r_dataBuf;
   assign iact_write_en         = r_writeEn;
   assign addr_count            = r_addrCnt;
   assign data_count            = r_dataCnt;
   assign overflow_err          = r_overflowErr;
   assign seq_err               = r_seqErr;

endmodule

// File: tb/tb_iact_glb_loader.sv
// tb_iact_glb_loader: directed bench for iact_glb_loader with the address
// depth shrunk to 4 so the forced end sign can be reached quickly.
module tb_iact_glb_loader;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 12;
   localparam int CNT_W  = 11;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              load_start = 1'b0;
   logic              busy;
   logic              load_done;
   logic              src_valid = 1'b0;
   logic              src_ready;
   logic [12:0]       src_data = '0;
   logic              iact_address_in_valid;
   logic              iact_address_in_ready = 1'b1;
   logic [ADDR_W-1:0] iact_address_in;
   logic              iact_data_in_valid;
   logic              iact_data_in_ready = 1'b1;
   logic [DATA_W-1:0] iact_data_in;
   logic              iact_write_en;
   logic              iact_write_done = 1'b0;
   logic [CNT_W-1:0]  addr_count;
   logic [CNT_W-1:0]  data_count;
   logic              overflow_err;
   logic              seq_err;

   int                total = 0;
   int                bad = 0;
   int                wePulses = 0;
   logic [31:0]       addrQ[$];
   logic [31:0]       dataQ[$];

   iact_glb_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_DEPTH(4), .DATA_DEPTH(1024), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .load_start(load_start), .busy(busy),
      .load_done(load_done), .src_valid(src_valid), .src_ready(src_ready),
      .src_data(src_data), .iact_address_in_valid(iact_address_in_valid),
      .iact_address_in_ready(iact_address_in_ready), .iact_address_in(iact_address_in),
      .iact_data_in_valid(iact_data_in_valid), .iact_data_in_ready(iact_data_in_ready),
      .iact_data_in(iact_data_in), .iact_write_en(iact_write_en),
      .iact_write_done(iact_write_done), .addr_count(addr_count), .data_count(data_count),
      .overflow_err(overflow_err), .seq_err(seq_err)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clock = ~clock;

   // Bank-side monitor: records every beat that drains and every write-enable pulse.
   always @(posedge clock) begin
      if (!reset && iact_address_in_valid && iact_address_in_ready) begin
         addrQ.push_back(32'(iact_address_in));
      end
      if (!reset && iact_data_in_valid && iact_data_in_ready) begin
         dataQ.push_back(32'(iact_data_in));
      end
      if (!reset && iact_write_en) begin
         wePulses++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [12:0] word, input string tag);
      logic ok;
      ok = 1'b0;
      src_valid = 1'b1;
      src_data  = word;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         if (src_ready) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      src_valid = 1'b0;
      checkOutput({tag, " accepted"}, 32'(ok), 32'd1);
   endtask

   task automatic startLoad(input string tag);
      load_start = 1'b1;
      @(posedge clock);
      #1;
      load_start = 1'b0;
      checkOutput({tag, " write_en"}, 32'(iact_write_en), 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic waitLoadDone(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (load_done) found = 1'b1;
         else begin
            @(posedge clock);
            #1;
         end
      end
      checkOutput({tag, " load_done"}, 32'(found), 32'd1);
      @(posedge clock);
      #1;
      checkOutput({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   task automatic finishLoad(input string tag);
      repeat (2) @(posedge clock);
      #1;
      iact_write_done = 1'b1;
      @(posedge clock);
      #1;
      iact_write_done = 1'b0;
      waitLoadDone(tag);
   endtask

   task automatic checkStream(input string tag, input bit isAddr, input int base, input int n,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      int sz;
      logic [31:0] v;
      logic [31:0] e;
      sz = isAddr ? addrQ.size() : dataQ.size();
      checkOutput({tag, " beats"}, 32'(sz - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         v = 32'hFFFF_FFFF;
         if (base + i < sz) v = isAddr ? addrQ[base + i] : dataQ[base + i];
         e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
         checkOutput($sformatf("%s beat%0d", tag, i), v, e);
      end
   endtask

   // Directed test sequence.
   initial begin
      int aBase;
      int dBase;
      int weBase;

      #3;
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst addr_valid", 32'(iact_address_in_valid), 32'd0);
      checkOutput("rst data_valid", 32'(iact_data_in_valid), 32'd0);
      checkOutput("rst write_en", 32'(iact_write_en), 32'd0);
      checkOutput("rst src_ready", 32'(src_ready), 32'd0);
      checkOutput("rst addr_count", 32'(addr_count), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;

      $display("[TB] basic load");
      aBase = addrQ.size(); dBase = dataQ.size(); weBase = wePulses;
      startLoad("t1");
      applyStimulus(13'h1003, "t1 a3");
      checkOutput("t1 latency valid", 32'(iact_address_in_valid), 32'd1);
      checkOutput("t1 latency payload", 32'(iact_address_in), 32'd3);
      applyStimulus(13'h1005, "t1 a5");
      applyStimulus(13'h1000, "t1 a0");
      applyStimulus(13'h0011, "t1 d11");
      applyStimulus(13'h0022, "t1 d22");
      applyStimulus(13'h0000, "t1 d0");
      finishLoad("t1");
      checkStream("t1 addr", 1'b1, aBase, 3, 32'd3, 32'd5, 32'd0, 32'd0);
      checkStream("t1 data", 1'b0, dBase, 3, 32'h011, 32'h022, 32'h000, 32'd0);
      checkOutput("t1 addr_count", 32'(addr_count), 32'd3);
      checkOutput("t1 data_count", 32'(data_count), 32'd3);
      checkOutput("t1 we pulses", 32'(wePulses - weBase), 32'd1);
      checkOutput("t1 overflow", 32'(overflow_err), 32'd0);

      $display("[TB] backpressure");
      aBase = addrQ.size(); dBase = dataQ.size();
      startLoad("t2");
      applyStimulus(13'h1000, "t2 a0");
      applyStimulus(13'h0101, "t2 d101");
      iact_data_in_ready = 1'b0;
      src_valid = 1'b1;
      src_data  = 13'h0202;
      #1;
      checkOutput("t2 stall src_ready", 32'(src_ready), 32'd0);
      checkOutput("t2 stall valid", 32'(iact_data_in_valid), 32'd1);
      checkOutput("t2 stall payload", 32'(iact_data_in), 32'h101);
      @(posedge clock);
      #1;
      checkOutput("t2 stall2 src_ready", 32'(src_ready), 32'd0);
      checkOutput("t2 stall2 payload", 32'(iact_data_in), 32'h101);
      @(posedge clock);
      #1;
      iact_data_in_ready = 1'b1;
      applyStimulus(13'h0202, "t2 d202");
      applyStimulus(13'h0303, "t2 d303");
      applyStimulus(13'h0000, "t2 d0");
      finishLoad("t2");
      checkStream("t2 data", 1'b0, dBase, 4, 32'h101, 32'h202, 32'h303, 32'h000);
      checkOutput("t2 data_count", 32'(data_count), 32'd4);

      $display("[TB] overflow");
      aBase = addrQ.size(); dBase = dataQ.size();
      startLoad("t3");
      applyStimulus(13'h1001, "t3 a1");
      applyStimulus(13'h1002, "t3 a2");
      applyStimulus(13'h1003, "t3 a3");
      applyStimulus(13'h1007, "t3 a7");
      checkOutput("t3 overflow_err", 32'(overflow_err), 32'd1);
      checkOutput("t3 seq_err before", 32'(seq_err), 32'd0);
      applyStimulus(13'h1009, "t3 a9");
      checkOutput("t3 seq_err", 32'(seq_err), 32'd1);
      checkOutput("t3 addr_count", 32'(addr_count), 32'd4);
      applyStimulus(13'h0000, "t3 d0");
      finishLoad("t3");
      checkStream("t3 addr", 1'b1, aBase, 4, 32'd1, 32'd2, 32'd3, 32'd0);
      checkOutput("t3 addr_count end", 32'(addr_count), 32'd4);
      checkOutput("t3 overflow hold", 32'(overflow_err), 32'd1);

      $display("[TB] early done");
      dBase = dataQ.size();
      startLoad("t4");
      checkOutput("t4 overflow cleared", 32'(overflow_err), 32'd0);
      checkOutput("t4 seq cleared", 32'(seq_err), 32'd0);
      applyStimulus(13'h1000, "t4 a0");
      applyStimulus(13'h0055, "t4 d55");
      applyStimulus(13'h0000, "t4 d0");
      checkOutput("t4 final beat valid", 32'(iact_data_in_valid), 32'd1);
      checkOutput("t4 final beat payload", 32'(iact_data_in), 32'd0);
      iact_write_done = 1'b1;
      @(posedge clock);
      #1;
      iact_write_done = 1'b0;
      waitLoadDone("t4");
      checkStream("t4 data", 1'b0, dBase, 2, 32'h055, 32'h000, 32'd0, 32'd0);

      $display("[TB] reset mid-stream");
      startLoad("t5");
      applyStimulus(13'h1001, "t5 a1");
      applyStimulus(13'h1002, "t5 a2");
      reset = 1'b1;
      #1;
      checkOutput("t5 busy", 32'(busy), 32'd0);
      checkOutput("t5 addr_valid", 32'(iact_address_in_valid), 32'd0);
      checkOutput("t5 addr_payload", 32'(iact_address_in), 32'd0);
      checkOutput("t5 addr_count", 32'(addr_count), 32'd0);
      checkOutput("t5 src_ready", 32'(src_ready), 32'd0);
      weBase = wePulses;
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("t5 no stray write_en", 32'(wePulses - weBase), 32'd0);
      aBase = addrQ.size(); dBase = dataQ.size();
      startLoad("t5b");
      checkOutput("t5b addr_count start", 32'(addr_count), 32'd0);
      applyStimulus(13'h1000, "t5b a0");
      applyStimulus(13'h0000, "t5b d0");
      finishLoad("t5b");
      checkStream("t5b addr", 1'b1, aBase, 1, 32'd0, 32'd0, 32'd0, 32'd0);
      checkOutput("t5b addr_count", 32'(addr_count), 32'd1);
      checkOutput("t5b data_count", 32'(data_count), 32'd1);

      $display("[TB] ignored start");
      weBase = wePulses;
      startLoad("t6");
      applyStimulus(13'h1004, "t6 a4");
      load_start = 1'b1;
      @(posedge clock);
      #1;
      load_start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("t6 addr_count kept", 32'(addr_count), 32'd1);
      checkOutput("t6 we pulses", 32'(wePulses - weBase), 32'd1);
      checkOutput("t6 busy", 32'(busy), 32'd1);
      applyStimulus(13'h1000, "t6 a0");
      applyStimulus(13'h0000, "t6 d0");
      finishLoad("t6");
      checkOutput("t6 addr_count", 32'(addr_count), 32'd2);
      checkOutput("t6 data_count", 32'(data_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
